// File: rtl/fmul_batch_master_if.sv
// rtl/fmul_batch_master_if.sv - operand A/B and result streams between batch master and float multiplier
interface fmul_batch_master_if #(
    parameter int DATA_W = 32
);
    logic              s_axis_a_tvalid;
    logic              s_axis_a_tready;
    logic [DATA_W-1:0] s_axis_a_tdata;
    logic              s_axis_b_tvalid;
    logic              s_axis_b_tready;
    logic [DATA_W-1:0] s_axis_b_tdata;
    logic              m_axis_result_tvalid;
    logic              m_axis_result_tready;
    logic [DATA_W-1:0] m_axis_result_tdata;

    modport master (
        output s_axis_a_tvalid, s_axis_a_tdata,
        input  s_axis_a_tready,
        output s_axis_b_tvalid, s_axis_b_tdata,
        input  s_axis_b_tready,
        input  m_axis_result_tvalid, m_axis_result_tdata,
        output m_axis_result_tready
    );

    modport slave (
        input  s_axis_a_tvalid, s_axis_a_tdata,
        output s_axis_a_tready,
        input  s_axis_b_tvalid, s_axis_b_tdata,
        output s_axis_b_tready,
        output m_axis_result_tvalid, m_axis_result_tdata,
        input  m_axis_result_tready
    );
endinterface

// File: rtl/fmul_batch_master.sv
// rtl/fmul_batch_master.sv - batch operand issuer and result collector for the float multiplier
module fmul_batch_master #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  ld_valid,
    output logic                  ld_ready,
    input  logic [DATA_W-1:0]     ld_a,
    input  logic [DATA_W-1:0]     ld_b,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    fmul_batch_master_if.master   M,
    input  logic                  rd_en,
    output logic [DATA_W-1:0]     rd_data,
    output logic [ADDR_W:0]       rd_count
);
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

    localparam logic [ADDR_W:0]   FULL  = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   ONE   = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] ONE_P = ADDR_W'(1);

    state_t            state;
    logic [ADDR_W:0]   n_pairs;
    logic [ADDR_W:0]   iss_ptr;
    logic [ADDR_W:0]   res_cnt;
    logic [ADDR_W-1:0] rd_ptr;
    logic              a_done;
    logic              b_done;
    logic              ld_en;

    logic [DATA_W-1:0] pair_a [DEPTH];
    logic [DATA_W-1:0] pair_b [DEPTH];
    logic [DATA_W-1:0] res    [DEPTH];

    logic [ADDR_W-1:0] iss_idx;
    logic              a_hs;
    logic              b_hs;
    logic              a_fin;
    logic              b_fin;
    logic              ld_take;
    logic              res_take;

    assign iss_idx  = iss_ptr[ADDR_W-1:0];
    // ld_en holds ld_ready low while aresetn is asserted, when the state alone would allow loads
    assign ld_ready = ld_en && (state == S_IDLE) && (n_pairs < FULL);
    assign ld_take  = ld_ready && ld_valid && !start;
    assign busy     = (state != S_IDLE);

    assign M.s_axis_a_tvalid      = (state == S_ISSUE) && !a_done;
    assign M.s_axis_b_tvalid      = (state == S_ISSUE) && !b_done;
    assign M.s_axis_a_tdata       = M.s_axis_a_tvalid ? pair_a[iss_idx] : '0;
    assign M.s_axis_b_tdata       = M.s_axis_b_tvalid ? pair_b[iss_idx] : '0;
    assign M.m_axis_result_tready = ((state == S_ISSUE) || (state == S_DRAIN)) && (res_cnt < n_pairs);

    assign a_hs     = M.s_axis_a_tvalid && M.s_axis_a_tready;
    assign b_hs     = M.s_axis_b_tvalid && M.s_axis_b_tready;
    assign a_fin    = a_done || a_hs;
    assign b_fin    = b_done || b_hs;
    assign res_take = M.m_axis_result_tready && M.m_axis_result_tvalid;

    // Load gate: opens one cycle after reset release
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) ld_en <= 1'b0;
        else          ld_en <= 1'b1;
    end

    // Operand-pair and result storage; contents are meaningful only via the counters
    always_ff @(posedge aclk) begin
        if (ld_take) begin
            pair_a[n_pairs[ADDR_W-1:0]] <= ld_a;
            pair_b[n_pairs[ADDR_W-1:0]] <= ld_b;
        end
        if (res_take) res[res_cnt[ADDR_W-1:0]] <= M.m_axis_result_tdata;
    end

    // Batch FSM: load/read in IDLE, issue pairs, drain products, pulse done
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state    <= S_IDLE;
            n_pairs  <= '0;
            iss_ptr  <= '0;
            res_cnt  <= '0;
            rd_ptr   <= '0;
            rd_count <= '0;
            a_done   <= 1'b0;
            b_done   <= 1'b0;
            done     <= 1'b0;
            rd_data  <= '0;
        end else begin
            done <= 1'b0;
            if (res_take) res_cnt <= res_cnt + ONE;
            case (state)
                S_IDLE: begin
                    if (ld_take) n_pairs <= n_pairs + ONE;
                    if (rd_en && (rd_count != '0)) begin
                        rd_data  <= res[rd_ptr];
                        rd_ptr   <= rd_ptr + ONE_P;
                        rd_count <= rd_count - ONE;
                    end
                    // start discards unread results and overrides a same-cycle read
                    if (start) begin
                        rd_ptr   <= '0;
                        rd_count <= '0;
                        if (n_pairs != '0) begin
                            state   <= S_ISSUE;
                            iss_ptr <= '0;
                            res_cnt <= '0;
                            a_done  <= 1'b0;
                            b_done  <= 1'b0;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                S_ISSUE: begin
                    if (a_fin && b_fin) begin
                        a_done  <= 1'b0;
                        b_done  <= 1'b0;
                        iss_ptr <= iss_ptr + ONE;
                        if (iss_ptr == n_pairs - ONE) state <= S_DRAIN;
                    end else begin
                        a_done <= a_fin;
                        b_done <= b_fin;
                    end
                end
                S_DRAIN: begin
                    if (res_cnt == n_pairs) begin
                        state    <= S_DONE;
                        done     <= 1'b1;
                        rd_count <= n_pairs;
                    end
                end
                default: begin
                    n_pairs <= '0;
                    state   <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fmul_batch_master.sv
// tb/tb_fmul_batch_master.sv - bench for fmul_batch_master with a behavioural float multiplier
module tb_fmul_batch_master;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;

    logic              aclk = 1'b0;
    logic              aresetn = 1'b0;
    logic              ld_valid = 1'b0;
    logic              ld_ready;
    logic [DATA_W-1:0] ld_a = '0;
    logic [DATA_W-1:0] ld_b = '0;
    logic              start = 1'b0;
    logic              busy;
    logic              done;
    logic              rd_en = 1'b0;
    logic [DATA_W-1:0] rd_data;
    logic [ADDR_W:0]   rd_count;

    always #5 aclk = ~aclk;

    fmul_batch_master_if #(.DATA_W(DATA_W)) M ();

    fmul_batch_master #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .aclk     (aclk),
        .aresetn  (aresetn),
        .ld_valid (ld_valid),
        .ld_ready (ld_ready),
        .ld_a     (ld_a),
        .ld_b     (ld_b),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .M        (M),
        .rd_en    (rd_en),
        .rd_data  (rd_data),
        .rd_count (rd_count)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic real f2r(input logic [31:0] f);
        real m;
        m = 1.0 + real'(f[22:0]) / 8388608.0;
        if (f[31]) m = -m;
        return m * (2.0 ** (real'(int'(f[30:23])) - 127.0));
    endfunction

    // Exact IEEE single product for the operand range used here
    function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
        logic [63:0] d;
        d = $realtobits(f2r(a) * f2r(b));
        return {d[63], 8'(d[62:52] - 11'd896), d[51:29]};
    endfunction

    function automatic logic [31:0] rand_op();
        logic [31:0] v;
        v = {1'($urandom_range(1, 0)), 8'($urandom_range(134, 120)), 8'($urandom_range(255, 0)), 15'd0};
        return v;
    endfunction

    // Multiplier model controls and state
    typedef struct { logic [31:0] d; int t; } prod_t;
    logic [31:0] qa[$];
    logic [31:0] qb[$];
    prod_t       qr[$];
    int  cyc = 0;
    bit  a_rand = 0, b_hold = 0, r_gap = 0, r_extra = 0, junk_on = 0;
    int  lat_min = 8, lat_max = 8;
    int  b_acc = 0, r_acc = 0, exp_n = 0, junk_taken = 0;
    logic        a_hs_q = 0, b_hs_q = 0, r_hs_q = 0;
    logic [31:0] a_d_q = 0, b_d_q = 0;

    always @(posedge aclk) begin
        a_hs_q <= M.s_axis_a_tvalid & M.s_axis_a_tready;
        b_hs_q <= M.s_axis_b_tvalid & M.s_axis_b_tready;
        r_hs_q <= M.m_axis_result_tvalid & M.m_axis_result_tready;
        a_d_q  <= M.s_axis_a_tdata;
        b_d_q  <= M.s_axis_b_tdata;
    end

    always @(negedge aclk) begin : mult_model
        prod_t p;
        cyc++;
        if (!aresetn) begin
            qa.delete(); qb.delete(); qr.delete();
            M.s_axis_a_tready      = 1'b0;
            M.s_axis_b_tready      = 1'b0;
            M.m_axis_result_tvalid = 1'b0;
            M.m_axis_result_tdata  = '0;
            junk_on = 0;
        end else begin
            if (a_hs_q) qa.push_back(a_d_q);
            if (b_hs_q) begin qb.push_back(b_d_q); b_acc++; end
            while (qa.size() > 0 && qb.size() > 0) begin
                p.d = fmul(qa.pop_front(), qb.pop_front());
                p.t = cyc + $urandom_range(lat_max, lat_min);
                qr.push_back(p);
            end
            if (r_hs_q) begin
                r_acc++;
                if (junk_on) junk_taken++;
                else if (qr.size() > 0) void'(qr.pop_front());
                M.m_axis_result_tvalid = 1'b0;
                junk_on = 0;
            end
            if (junk_on && !r_extra) begin
                M.m_axis_result_tvalid = 1'b0;
                junk_on = 0;
            end
            if (!M.m_axis_result_tvalid) begin
                if (qr.size() > 0 && qr[0].t <= cyc && (!r_gap || $urandom_range(1, 0) == 1)) begin
                    M.m_axis_result_tvalid = 1'b1;
                    M.m_axis_result_tdata  = qr[0].d;
                end else if (r_extra && qr.size() == 0 && r_acc == exp_n) begin
                    M.m_axis_result_tvalid = 1'b1;
                    M.m_axis_result_tdata  = 32'hDEADBEEF;
                    junk_on = 1;
                end
            end
            M.s_axis_a_tready = a_rand ? 1'($urandom_range(1, 0)) : 1'b1;
            M.s_axis_b_tready = b_hold ? 1'b0 : (a_rand ? 1'($urandom_range(1, 0)) : 1'b1);
        end
    end

    // Operand streams must hold valid and data until accepted
    logic        hold_a = 0, hold_b = 0;
    logic [31:0] hold_ad = 0, hold_bd = 0;
    always @(posedge aclk) begin
        if (!aresetn) begin
            hold_a <= 0;
            hold_b <= 0;
        end else begin
            if (hold_a) begin
                chk("a_tvalid_hold", M.s_axis_a_tvalid, 1);
                chk("a_tdata_hold", M.s_axis_a_tdata, hold_ad);
            end
            if (hold_b) begin
                chk("b_tvalid_hold", M.s_axis_b_tvalid, 1);
                chk("b_tdata_hold", M.s_axis_b_tdata, hold_bd);
            end
            hold_a  <= M.s_axis_a_tvalid & !M.s_axis_a_tready;
            hold_b  <= M.s_axis_b_tvalid & !M.s_axis_b_tready;
            hold_ad <= M.s_axis_a_tdata;
            hold_bd <= M.s_axis_b_tdata;
        end
    end

    // Reference: loaded pairs and the products the host should read back, in load order
    logic [31:0] pa[$];
    logic [31:0] pb[$];
    logic [31:0] exp_q[$];

    task automatic load(input logic [31:0] a, input logic [31:0] b);
        bit exp_rdy;
        exp_rdy = (pa.size() < DEPTH);
        chk("ld_ready", ld_ready, exp_rdy);
        ld_valid = 1'b1; ld_a = a; ld_b = b;
        @(negedge aclk);
        ld_valid = 1'b0;
        if (exp_rdy) begin pa.push_back(a); pb.push_back(b); end
    endtask

    task automatic fill_exp();
        exp_q.delete();
        foreach (pa[i]) exp_q.push_back(fmul(pa[i], pb[i]));
    endtask

    task automatic kick();
        exp_n = pa.size(); r_acc = 0; b_acc = 0; junk_taken = 0;
        start = 1'b1;
        @(negedge aclk);
        start = 1'b0;
        chk("busy_after_start", busy, 1);
    endtask

    task automatic finish_batch(input string tag);
        int n;
        bit got;
        n = exp_q.size();
        got = 0;
        for (int k = 0; k < 3000; k++) begin
            if (done) begin got = 1; break; end
            @(negedge aclk);
        end
        chk({tag, "_done_seen"}, got, 1);
        chk({tag, "_rd_count_at_done"}, rd_count, n);
        chk({tag, "_results_accepted"}, r_acc, n);
        chk({tag, "_extra_not_taken"}, junk_taken, 0);
        @(negedge aclk);
        r_extra = 0;
        chk({tag, "_done_single"}, done, 0);
        chk({tag, "_idle"}, busy, 0);
        for (int i = 0; i < n; i++) begin
            rd_en = 1'b1;
            @(negedge aclk);
            chk({tag, "_rd_data"}, rd_data, exp_q[i]);
            chk({tag, "_rd_count"}, rd_count, n - 1 - i);
        end
        rd_en = 1'b1;
        @(negedge aclk);
        rd_en = 1'b0;
        chk({tag, "_rd_empty_count"}, rd_count, 0);
        chk({tag, "_rd_empty_data"}, rd_data, exp_q[n-1]);
        exp_q.delete(); pa.delete(); pb.delete();
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge aclk);
        chk("rst_ld_ready", ld_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_a_tvalid", M.s_axis_a_tvalid, 0);
        chk("rst_b_tvalid", M.s_axis_b_tvalid, 0);
        chk("rst_result_tready", M.m_axis_result_tready, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_rd_count", rd_count, 0);
        aresetn = 1'b1;
        repeat (2) @(negedge aclk);
        chk("post_rst_ld_ready", ld_ready, 1);

        // T1: fixed operands, latency 8, all readies high
        load(32'h42800000, 32'h42800000);
        load(32'h42000000, 32'h42000000);
        load(32'h41800000, 32'h41800000);
        load(32'h41000000, 32'h41000000);
        load(32'h40800000, 32'h40800000);
        load(32'h40000000, 32'h40000000);
        exp_q = '{32'h45800000, 32'h44800000, 32'h43800000, 32'h42800000, 32'h41800000, 32'h40800000};
        kick();
        finish_batch("t1");

        // T2: B channel stalled for 5 cycles while A is ready
        for (int i = 0; i < 3; i++) load(rand_op(), rand_op());
        fill_exp();
        b_hold = 1;
        @(negedge aclk);
        kick();
        chk("t2_a_tvalid_first", M.s_axis_a_tvalid, 1);
        chk("t2_a_tdata_first", M.s_axis_a_tdata, pa[0]);
        chk("t2_b_tdata_first", M.s_axis_b_tdata, pb[0]);
        for (int i = 0; i < 4; i++) begin
            @(negedge aclk);
            chk("t2_a_tvalid_dropped", M.s_axis_a_tvalid, 0);
            chk("t2_b_tvalid_held", M.s_axis_b_tvalid, 1);
            chk("t2_b_tdata_held", M.s_axis_b_tdata, pb[0]);
        end
        b_hold = 0;
        finish_batch("t2");

        // T3: random readies, result gaps, random latency, extra product offered
        a_rand = 1; r_gap = 1; lat_min = 1; lat_max = 12;
        for (int i = 0; i < 10; i++) load(rand_op(), rand_op());
        fill_exp();
        kick();
        r_extra = 1;
        finish_batch("t3");
        a_rand = 0; r_gap = 0; lat_min = 8; lat_max = 8;

        // T4: full buffer, 17th load dropped
        for (int i = 0; i < DEPTH; i++) load(32'h40800000, 32'h40800000);
        chk("t4_ld_ready_full", ld_ready, 0);
        load(32'h3F800000, 32'h3F800000);
        chk("t4_ld_ready_still_full", ld_ready, 0);
        exp_q.delete();
        for (int i = 0; i < DEPTH; i++) exp_q.push_back(32'h41800000);
        kick();
        finish_batch("t4");

        // T5: start with no pairs loaded
        chk("t5_rd_count_before", rd_count, 0);
        start = 1'b1;
        @(negedge aclk);
        start = 1'b0;
        chk("t5_done", done, 1);
        chk("t5_busy", busy, 0);
        chk("t5_rd_count", rd_count, 0);
        @(negedge aclk);
        chk("t5_done_single", done, 0);
        chk("t5_busy_after", busy, 0);

        // T6: asynchronous reset in the middle of a batch
        lat_min = 20; lat_max = 20;
        for (int i = 0; i < 8; i++) load(rand_op(), rand_op());
        kick();
        begin
            bit reached;
            reached = 0;
            for (int k = 0; k < 200; k++) begin
                if (b_acc >= 3) begin reached = 1; break; end
                @(negedge aclk);
            end
            chk("t6_three_retired", reached, 1);
        end
        #2 aresetn = 1'b0;
        #1;
        chk("t6_ld_ready", ld_ready, 0);
        chk("t6_busy", busy, 0);
        chk("t6_done", done, 0);
        chk("t6_a_tvalid", M.s_axis_a_tvalid, 0);
        chk("t6_b_tvalid", M.s_axis_b_tvalid, 0);
        chk("t6_a_tdata", M.s_axis_a_tdata, 0);
        chk("t6_b_tdata", M.s_axis_b_tdata, 0);
        chk("t6_result_tready", M.m_axis_result_tready, 0);
        chk("t6_rd_data", rd_data, 0);
        chk("t6_rd_count", rd_count, 0);
        pa.delete(); pb.delete();
        repeat (2) @(negedge aclk);
        aresetn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge aclk);
            chk("t6_no_done", done, 0);
            chk("t6_idle", busy, 0);
        end
        chk("t6_ld_ready_after", ld_ready, 1);
        chk("t6_rd_count_after", rd_count, 0);

        // Recovery: a fresh batch holds only the newly loaded pairs
        lat_min = 3; lat_max = 9;
        for (int i = 0; i < 2; i++) load(rand_op(), rand_op());
        fill_exp();
        kick();
        finish_batch("t6_recover");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
